// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the Ascon permutation datapath: walks the round-constant
// index from the mode's start value up to 11, then pulses done_o for one cycle.
module ascon_perm_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       ready_o,
  output logic [3:0] round_o,
  output logic       init_o,
  output logic       en_reg_o,
  output logic       done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIRST = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [3:0] LOAD_A     = 4'(12 - ROUNDS_A);
  localparam logic [3:0] LOAD_B     = 4'(12 - ROUNDS_B);

  generate
    if (ROUNDS_B < 1 || ROUNDS_B > ROUNDS_A || ROUNDS_A > 12) begin : g_bad_rounds
      $error("ascon_perm_ctrl: need 1 <= ROUNDS_B <= ROUNDS_A <= 12");
    end
  endgenerate

  logic [1:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // The counter captures the mode at acceptance, so mode_i is never looked at again.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_FIRST;
          cnt_nxt   = mode_i ? LOAD_B : LOAD_A;
        end
      end
      S_FIRST, S_RUN: begin
        if (abort_i) begin
          state_nxt = S_IDLE;
        end else if (cnt == LAST_ROUND) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
          cnt_nxt   = cnt + 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Moore outputs: decoded from registered state and counter only.
  assign ready_o  = (state == S_IDLE);
  assign init_o   = (state == S_FIRST);
  assign en_reg_o = (state == S_FIRST) || (state == S_RUN);
  assign done_o   = (state == S_DONE);
  assign round_o  = cnt;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: a default instance and a ROUNDS_B=8 instance share
// the same stimulus and are both checked against a timeline model every cycle.
module tb_ascon_perm_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic abort = 1'b0;

  logic       d_ready[2];
  logic [3:0] d_round[2];
  logic       d_init[2];
  logic       d_en[2];
  logic       d_done[2];

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ascon_perm_ctrl dut_a (
    .clock_i (clk), .resetb_i (rst_n), .start_i (start), .mode_i (mode), .abort_i (abort),
    .ready_o (d_ready[0]), .round_o (d_round[0]), .init_o (d_init[0]),
    .en_reg_o (d_en[0]), .done_o (d_done[0])
  );

  ascon_perm_ctrl #(.ROUNDS_A(12), .ROUNDS_B(8)) dut_b8 (
    .clock_i (clk), .resetb_i (rst_n), .start_i (start), .mode_i (mode), .abort_i (abort),
    .ready_o (d_ready[1]), .round_o (d_round[1]), .init_o (d_init[1]),
    .en_reg_o (d_en[1]), .done_o (d_done[1])
  );

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: k = cycles since acceptance (0 = idle); cycles 1..n are enabled,
  // cycle n+1 is the done pulse.
  int k[2] = '{0, 0};
  int n[2] = '{12, 12};
  int nb[2] = '{6, 8};
  bit fresh[2] = '{1'b1, 1'b1};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        k[i] = 0;
        fresh[i] = 1'b1;
      end else if (k[i] == 0) begin
        if (start) begin
          k[i] = 1;
          n[i] = mode ? nb[i] : 12;
          fresh[i] = 1'b0;
        end
      end else if (k[i] <= n[i] && abort) begin
        k[i] = 0;
      end else if (k[i] == n[i] + 1) begin
        k[i] = 0;
      end else begin
        k[i] = k[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ready[%0d]", i), int'(d_ready[i]), int'(k[i] == 0));
      check($sformatf("init[%0d]", i), int'(d_init[i]), int'(k[i] == 1));
      check($sformatf("en[%0d]", i), int'(d_en[i]), int'(k[i] >= 1 && k[i] <= n[i]));
      check($sformatf("done[%0d]", i), int'(d_done[i]), int'(k[i] == n[i] + 1));
      if (k[i] >= 1 && k[i] <= n[i])
        check($sformatf("round[%0d]", i), int'(d_round[i]), 12 - n[i] + k[i] - 1);
      else if (k[i] == 0 && fresh[i])
        check($sformatf("round_rst[%0d]", i), int'(d_round[i]), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, int'(d_ready[0]), 1);
    check({tag, "_round"}, int'(d_round[0]), 0);
    check({tag, "_init"}, int'(d_init[0]), 0);
    check({tag, "_en"}, int'(d_en[0]), 0);
    check({tag, "_done"}, int'(d_done[0]), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_outs("por");
    tick(); tick();

    // Release with start already high: the very next edge accepts a p^a run.
    rst_n = 1'b1; start = 1'b1; mode = 1'b0;
    tick(); start = 1'b0;
    check("pa_first_init", int'(d_init[0]), 1);
    check("pa_first_round", int'(d_round[0]), 0);
    repeat (11) tick();
    check("pa_last_round", int'(d_round[0]), 11);
    check("pa_last_en", int'(d_en[0]), 1);
    tick();
    check("pa_done", int'(d_done[0]), 1);
    tick();
    check("pa_ready_after", int'(d_ready[0]), 1);

    // p^b on both instances (6 rounds vs 8 rounds).
    start = 1'b1; mode = 1'b1;
    tick(); start = 1'b0;
    check("pb_first_round", int'(d_round[0]), 6);
    check("pb8_first_round", int'(d_round[1]), 4);
    repeat (5) tick();
    check("pb_last_round", int'(d_round[0]), 11);
    tick();
    check("pb_done", int'(d_done[0]), 1);
    check("pb8_round10", int'(d_round[1]), 10);
    tick(); tick();
    check("pb8_done", int'(d_done[1]), 1);
    tick();

    // start held high with mode toggling every cycle: only the acceptance sample matters.
    start = 1'b1; mode = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 12) check("busy_done", int'(d_done[0]), 1);
      if (c == 13) check("busy_idle_gap", int'(d_ready[0]), 1);
      if (c == 14) check("busy_restart_round", int'(d_round[0]), 0);
      mode = ~mode;
    end
    start = 1'b0; mode = 1'b0;
    repeat (14) tick();

    // Abort at round 5 of p^a.
    start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    check("abort_at_round", int'(d_round[0]), 5);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("abort_ready", int'(d_ready[0]), 1);
    check("abort_en", int'(d_en[0]), 0);
    check("abort_done", int'(d_done[0]), 0);
    repeat (3) tick();

    // abort together with start in IDLE: start wins; abort in DONE is ignored.
    start = 1'b1; abort = 1'b1; mode = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    check("idle_abort_init", int'(d_init[0]), 1);
    repeat (6) tick();
    abort = 1'b1;
    check("done_abort_pulse", int'(d_done[0]), 1);
    tick(); abort = 1'b0;
    check("done_abort_ready", int'(d_ready[0]), 1);
    check("b8_aborted_ready", int'(d_ready[1]), 1);
    tick();

    // Asynchronous reset between edges mid-run, then restart with p^b.
    start = 1'b1; mode = 1'b0;
    tick(); start = 1'b0;
    repeat (4) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outs("async");
    @(posedge clk);
    #1 rst_n = 1'b1; start = 1'b1; mode = 1'b1;
    tick(); start = 1'b0;
    check("rst_pb_first_round", int'(d_round[0]), 6);
    repeat (5) tick();
    check("rst_pb_last_round", int'(d_round[0]), 11);
    tick();
    check("rst_pb_done", int'(d_done[0]), 1);
    tick();
    check("rst_pb_ready", int'(d_ready[0]), 1);
    repeat (4) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
